des_sbox_prog_engine: RTL
=========================

// Module: des_sbox_prog_engine
// PURPOSE
//  Run-time loadable, parametrised S-box substitution engine for the SPI DES datapath.
//  - Holds NBOX lookup tables of 2^IN_W entries x OUT_W bits.
//  - Substitutes one NBOX*IN_W-bit word per transaction.
//  - Time-multiplexes LANES lookups per cycle, trading area for latency.
//  - Sits between the E-expansion/key-XOR stage and the P-permutation of the round function.
//  - Tables are written through a config port, so DES S1..S8 or any other cipher's boxes can be loaded.
// PARAMETERS
//  IN_W   6  lookup index width per box; entry index = box input used as a linear address
//  OUT_W  4  output width per box
//  NBOX   8  number of boxes per word
//  LANES  2  boxes looked up per cycle; NBOX % LANES == 0 is required (elaboration $error otherwise)
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous reset, active high
//  cfg_we     in   1            table write strobe
//  cfg_ready  out  1            1 = a cfg write is accepted this cycle
//  cfg_box    in   clog2(NBOX)  target box, 0 = box occupying in_data LSBs
//  cfg_addr   in   IN_W         entry index
//  cfg_data   in   OUT_W        entry value
//  in_valid   in   1            input word valid
//  in_ready   out  1            engine can accept a word
//  in_data    in   NBOX*IN_W    box k index = in_data[k*IN_W +: IN_W]
//  out_valid  out  1            result valid
//  out_ready  in   1            downstream accepts result
//  out_data   out  NBOX*OUT_W   box k result = out_data[k*OUT_W +: OUT_W]
//  err        out  1            sticky parity error; reads 0 when SBOX_PARITY_EN is undefined
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, cfg_ready=1, out_valid=0, out_data=0, err=0, lane counter=0.
//  Table contents are not reset; they are undefined until written.
//  FSM:
//   IDLE: in_ready=1, cfg_ready=1.
//    - in_valid -> latch in_data, cnt=0, go to RUN.
//    - cfg_we && in_valid in the same cycle: both are accepted; the write lands first (visible to this word).
//   RUN: in_ready=0, cfg_ready=0.
//    - Each cycle, boxes cnt*LANES .. cnt*LANES+LANES-1 are looked up (combinational table read).
//    - Results are written into their out_data slices; cnt++.
//    - cnt == NBOX/LANES-1 -> go to DONE.
//   DONE: out_valid=1, cfg_ready=0, in_ready=0.
//    - out_ready -> out_valid drops next cycle, go to IDLE.
//    - out_data is held stable until the handshake completes.
//  Latency: in handshake -> out_valid = NBOX/LANES + 1 cycles.
//   Defaults give 5 cycles. Throughput is one word per NBOX/LANES + 2 cycles.
//  Config handling:
//   - cfg_we while cfg_ready=0 is ignored, with no side effect; the master retries.
//   - Writes to the same box/addr: the last one wins.
//  out_data slices of boxes not yet processed keep their previous-word values during RUN.
//   Only the DONE value is meaningful.
//  Reset asserted mid-RUN/DONE:
//   - The word is discarded and out_valid clears immediately (asynchronous).
//   - Tables keep their contents.
//  Widths: cnt is clog2(NBOX/LANES) bits (minimum 1). No arithmetic on data paths.
// CONFIGURATION
//  SBOX_PARITY_EN defined:
//   - Each entry stores an extra even-parity bit, computed on cfg write.
//   - On every RUN lookup the parity is rechecked; a mismatch sets err.
//   - err stays 1 until rst. Data is still output unchanged.
//  SBOX_PARITY_EN undefined: no parity storage; err is tied to 0.
// TESTING
//  1 Load DES S8 (box 7): addr 0=13, 1=1, 63=11. Word with box7 index 0 and all others 0
//    -> out_data[31:28]=13, out_valid exactly 5 cycles after the in handshake.
//  2 Load all 8 boxes with f(a)=a[3:0]^k (k = box number). Random word -> every slice matches the model.
//    Repeat with LANES=1/4/8 -> latency 9/3/2.
//  3 Backpressure: hold out_ready=0 for 10 cycles in DONE.
//    -> out_data stable, in_ready=0, cfg_we ignored (the entry still reads its old value later).
//  4 Same-cycle cfg_we (box0, addr 5, data 9) and in_valid with box0 index 5 in IDLE -> box0 result 9.
//  5 Assert rst in cycle 2 of RUN -> out_valid=0, in_ready=1 after release.
//    Previously loaded entries are still correct.
//  6 SBOX_PARITY_EN: force-flip a stored bit via a hierarchical deposit, then look it up
//    -> err=1 and stays 1; without the macro err stays 0.

Source files
------------

// File: rtl/des_sbox_prog_engine.sv
// des_sbox_prog_engine: run-time loadable S-box substitution engine.
// Holds NBOX tables of 2^IN_W x OUT_W entries, written through a config port.
// Each word is substituted LANES boxes per cycle, and the result is held until
// the downstream side accepts it.
// Optional feature macro: SBOX_PARITY_EN (per-entry even parity with sticky err).
module des_sbox_prog_engine #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 4,
  parameter int NBOX  = 8,
  parameter int LANES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_we,
  output logic                                 cfg_ready,
  input  logic [(NBOX>1?$clog2(NBOX):1)-1:0]   cfg_box,
  input  logic [IN_W-1:0]                      cfg_addr,
  input  logic [OUT_W-1:0]                     cfg_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NBOX*IN_W-1:0]                 in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NBOX*OUT_W-1:0]                out_data,
  output logic                                 err
);

  localparam int STEPS = NBOX / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int BOX_W = (NBOX > 1) ? $clog2(NBOX) : 1;
  localparam int DEPTH = 1 << IN_W;
`ifdef SBOX_PARITY_EN
  localparam int ENT_W = OUT_W + 1;
`else
  localparam int ENT_W = OUT_W;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((NBOX % LANES) != 0) begin : g_bad_lanes
    $error("des_sbox_prog_engine: NBOX must be a multiple of LANES");
  end

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vld_q, vld_d;
  logic [NBOX*OUT_W-1:0] out_q, out_d;
  logic [NBOX*IN_W-1:0]  in_q;
  logic [ENT_W-1:0]      mem_q [NBOX][DEPTH];
  logic [ENT_W-1:0]      wr_ent;
  logic                  wr_en;
  logic [BOX_W-1:0]      box_sel;
  logic [IN_W-1:0]       idx;
  logic [ENT_W-1:0]      ent;
  int                    base;
`ifdef SBOX_PARITY_EN
  logic                  err_q, err_d;
`endif

  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);
  assign out_valid = vld_q;
  assign out_data  = out_q;
  // Writes are only taken in IDLE, so a write in the same cycle as an accepted
  // word is already in the table by the first RUN lookup.
  assign wr_en = cfg_we && (state_q == IDLE) &&
                 ({1'b0, cfg_box} < (BOX_W+1)'(NBOX));
`ifdef SBOX_PARITY_EN
  assign wr_ent = {^cfg_data, cfg_data};
  assign err    = err_q;
`else
  assign wr_ent = cfg_data;
  assign err    = 1'b0;
`endif

  // Table storage: no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cfg_box][cfg_addr] <= wr_ent;
  end

  // Input word capture on the accepting handshake.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && in_valid) in_q <= in_data;
  end

  // Next-state logic: FSM sequencing and LANES table lookups per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    out_d   = out_q;
`ifdef SBOX_PARITY_EN
    err_d   = err_q;
`endif
    box_sel = '0;
    idx     = '0;
    ent     = '0;
    base    = 0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          base    = int'(cnt_q) * LANES + l;
          box_sel = BOX_W'(base);
          idx     = in_q[base*IN_W +: IN_W];
          ent     = mem_q[box_sel][idx];
          out_d[base*OUT_W +: OUT_W] = ent[OUT_W-1:0];
`ifdef SBOX_PARITY_EN
          if (^ent) err_d = 1'b1;
`endif
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
          vld_d   = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State registers; async reset discards any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      out_q   <= '0;
`ifdef SBOX_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
`ifdef SBOX_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
